// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// Optional hit/miss statistics ports are enabled with ICACHE_STATS_EN.
package icache_pkg;

  localparam int DEF_LINES      = 8;
  localparam int DEF_LINE_BYTES = 4;
  localparam int DEF_ADDR_W     = 8;

  localparam int OFF_W = $clog2(DEF_LINE_BYTES);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W;

  localparam logic [7:0] NOP_WORD = 8'hC0;

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

endpackage

// File: rtl/icache_refill.sv
// Line refill sequencer: fetches a whole line in order over a req/ack port
// and emits array write strobes; a flush abandons the line in flight.
module icache_refill
  import icache_pkg::*;
#(
  parameter int TW = TAG_W,
  parameter int IW = IDX_W,
  parameter int OW = OFF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [TW-1:0]    tag_i,
  input  logic [IW-1:0]    idx_i,
  input  logic             mem_ack_i,
  output logic             busy_o,
  output logic             mem_req_o,
  output logic [TW+IW+OW-1:0] mem_addr_o,
  output logic             we_o,
  output logic             done_o,
  output logic [IW-1:0]    widx_o,
  output logic [OW-1:0]    woff_o
);

  localparam logic [OW-1:0] LAST = {OW{1'b1}};

  state_e               state_q, state_d;
  logic [OW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tag_q, tag_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 req_q, req_d;
  logic [TW+IW+OW-1:0]  addr_q, addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_o    = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = REFILL;
          tag_d   = tag_i;
          idx_d   = idx_i;
          cnt_d   = '0;
          req_d   = 1'b1;
          addr_d  = {tag_i, idx_i, {OW{1'b0}}};
        end
      end
      REFILL: begin
        // flush outranks any ack in the same cycle, including the last one
        if (flush_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (mem_ack_i) begin
          we_o  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            done_o  = 1'b1;
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            addr_d = {tag_q, idx_q, cnt_d};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == REFILL);
  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign widx_o     = idx_q;
  assign woff_o     = cnt_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with combinational hit path.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache
  import icache_pkg::*;
#(
  parameter int         LINES      = DEF_LINES,
  parameter int         LINE_BYTES = DEF_LINE_BYTES,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter logic [7:0] NOP_WORD   = icache_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_data,
  output logic              imem_valid,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int OW = $clog2(LINE_BYTES);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW - OW;

  logic [TW-1:0] a_tag;
  logic [IW-1:0] a_idx;
  logic [OW-1:0] a_off;

  assign {a_tag, a_idx, a_off} = imem_addr;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [7:0]       data_q [LINES][LINE_BYTES];

  logic          busy, we, done;
  logic [IW-1:0] widx;
  logic [OW-1:0] woff;
  logic          lookup, hit, start;

  assign lookup = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign hit    = !busy && lookup && !flush;
  assign start  = !busy && !lookup && !flush;

  assign imem_valid = hit;
  assign imem_data  = hit ? data_q[a_idx][a_off] : NOP_WORD;

  icache_refill #(
    .TW(TW),
    .IW(IW),
    .OW(OW)
  ) u_refill (
    .clk       (clk),
    .rst_n     (areset),
    .start_i   (start),
    .flush_i   (flush),
    .tag_i     (a_tag),
    .idx_i     (a_idx),
    .mem_ack_i (mem_ack),
    .busy_o    (busy),
    .mem_req_o (mem_req),
    .mem_addr_o(mem_addr),
    .we_o      (we),
    .done_o    (done),
    .widx_o    (widx),
    .woff_o    (woff)
  );

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (done) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // storage needs no reset: nothing is visible until its valid bit is set
  always_ff @(posedge clk) begin
    if (we) begin
      data_q[widx][woff] <= mem_data;
    end
    if (done) begin
      tag_q[widx] <= mem_addr[ADDR_W-1 -: TW];
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && hit_cnt_q != 16'hFFFF) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (start && miss_cnt_q != 16'hFFFF) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache against a byte memory returning addr^8'hA5.
// Statistics scenarios are included when ICACHE_STATS_EN is defined.
module tb_icache;

  logic       clk;
  logic       areset;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       imem_valid;
  logic       flush;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int wait_n = 1;
  int wcnt   = 0;

  icache dut (
    .clk       (clk),
    .areset    (areset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .imem_valid(imem_valid),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = mem_addr ^ 8'hA5;
  assign mem_ack  = mem_req && (wcnt == wait_n - 1);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!imem_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!imem_valid) begin
      errors++;
      $display("FAIL %s: refill timeout, imem_valid=%b after %0d cycles, expected 1",
               name, imem_valid, budget);
    end
  endtask

  task automatic test_reset();
    areset    = 1'b0;
    flush     = 1'b0;
    imem_addr = 8'h00;
    wait_n    = 1;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem: req=%b addr=%h, expected req=0 addr=00", mem_req, mem_addr);
    end
    checks++;
    if (imem_valid !== 1'b0 || imem_data !== 8'hC0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h, expected valid=0 data=c0",
               imem_valid, imem_data);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (imem_valid !== 1'b0 || imem_data !== 8'hC0) begin
      errors++;
      $display("FAIL first_miss: valid=%b data=%h, expected valid=0 data=c0",
               imem_valid, imem_data);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, expected req=1 addr=00", mem_req, mem_addr);
    end
    wait_valid(10, "first_refill");
    checks++;
    if (imem_data !== 8'hA5) begin
      errors++;
      $display("FAIL first_hit: data=%h, expected a5", imem_data);
    end
  endtask

  task automatic test_cold_miss();
    logic [7:0] exp;
    imem_addr = 8'h05;
    #1;
    checks++;
    if (imem_valid !== 1'b0 || imem_data !== 8'hC0) begin
      errors++;
      $display("FAIL cold_miss: valid=%b data=%h, expected valid=0 data=c0",
               imem_valid, imem_data);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = 8'h04 + 8'(k);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp) begin
        errors++;
        $display("FAIL cold_addr%0d: req=%b addr=%h, expected req=1 addr=%h",
                 k, mem_req, mem_addr, exp);
      end
    end
    tick();
    checks++;
    if (imem_valid !== 1'b1 || imem_data !== 8'hA0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL cold_hit: valid=%b data=%h req=%b, expected valid=1 data=a0 req=0",
               imem_valid, imem_data, mem_req);
    end
    imem_addr = 8'h06;
    #1;
    checks++;
    if (imem_valid !== 1'b1 || imem_data !== 8'hA3) begin
      errors++;
      $display("FAIL same_line: valid=%b data=%h, expected valid=1 data=a3",
               imem_valid, imem_data);
    end
  endtask

  task automatic test_conflict();
    imem_addr = 8'h25;
    #1;
    checks++;
    if (imem_valid !== 1'b0) begin
      errors++;
      $display("FAIL conflict_miss: valid=%b, expected 0", imem_valid);
    end
    wait_valid(10, "conflict_refill");
    checks++;
    if (imem_data !== 8'h80) begin
      errors++;
      $display("FAIL conflict_hit: data=%h, expected 80", imem_data);
    end
    imem_addr = 8'h05;
    #1;
    checks++;
    if (imem_valid !== 1'b0) begin
      errors++;
      $display("FAIL evicted: valid=%b, expected 0", imem_valid);
    end
    wait_valid(10, "evict_refill");
    checks++;
    if (imem_data !== 8'hA0) begin
      errors++;
      $display("FAIL evict_hit: data=%h, expected a0", imem_data);
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] exp;
    wait_n    = 3;
    imem_addr = 8'h45;
    #1;
    tick();
    for (int k = 0; k < 12; k++) begin
      exp = 8'h44 + 8'(k / 3);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp) begin
        errors++;
        $display("FAIL wait_addr%0d: req=%b addr=%h, expected req=1 addr=%h",
                 k, mem_req, mem_addr, exp);
      end
      tick();
    end
    checks++;
    if (mem_req !== 1'b0 || imem_valid !== 1'b1 || imem_data !== 8'hE0) begin
      errors++;
      $display("FAIL wait_done: req=%b valid=%b data=%h, expected req=0 valid=1 data=e0",
               mem_req, imem_valid, imem_data);
    end
    wait_n = 1;
  endtask

  task automatic test_flush_final_ack();
    imem_addr = 8'h6D;
    #1;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (mem_addr !== 8'h6F || mem_ack !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: addr=%h ack=%b, expected addr=6f ack=1", mem_addr, mem_ack);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (imem_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: valid=%b, expected 0", imem_valid);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (imem_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_line: valid=%b req=%b, expected valid=0 req=0",
               imem_valid, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h6C) begin
      errors++;
      $display("FAIL flush_rereq: req=%b addr=%h, expected req=1 addr=6c", mem_req, mem_addr);
    end
    wait_valid(10, "flush_refill");
    checks++;
    if (imem_data !== 8'hC8) begin
      errors++;
      $display("FAIL flush_hit: data=%h, expected c8", imem_data);
    end
    imem_addr = 8'h45;
    #1;
    checks++;
    if (imem_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_other: valid=%b, expected 0", imem_valid);
    end
    wait_valid(10, "other_refill");
    checks++;
    if (imem_data !== 8'hE0) begin
      errors++;
      $display("FAIL other_hit: data=%h, expected e0", imem_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 8'h6C + 8'(k);
      imem_addr = a;
      #1;
      checks++;
      if (imem_valid !== 1'b1 || imem_data !== (a ^ 8'hA5)) begin
        errors++;
        $display("FAIL b2b%0d: valid=%b data=%h, expected valid=1 data=%h",
                 k, imem_valid, imem_data, a ^ 8'hA5);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_refill();
    imem_addr = 8'h99;
    #1;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_req: req=%b, expected 1", mem_req);
    end
    areset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 8'h00 || imem_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: req=%b addr=%h valid=%b, expected req=0 addr=00 valid=0",
               mem_req, mem_addr, imem_valid);
    end
    tick();
    imem_addr = 8'h6C;
    areset    = 1'b1;
    #1;
    checks++;
    if (imem_valid !== 1'b0 || imem_data !== 8'hC0) begin
      errors++;
      $display("FAIL reset_inval: valid=%b data=%h, expected valid=0 data=c0",
               imem_valid, imem_data);
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    areset    = 1'b0;
    imem_addr = 8'h85;
    tick();
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: hit=%0d miss=%0d, expected 0 0", hit_count, miss_count);
    end
    areset = 1'b1;
    #1;
    wait_valid(10, "stats_refill");
    repeat (4) tick();
    checks++;
    if (hit_count !== 16'd4 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL stats_count: hit=%0d miss=%0d, expected 4 1", hit_count, miss_count);
    end
    force dut.hit_cnt_q = 16'hFFFF;
    #1;
    release dut.hit_cnt_q;
    tick();
    tick();
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat: hit=%h, expected ffff", hit_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_wait_states();
    test_flush_final_ack();
    test_back_to_back();
    test_reset_mid_refill();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the cpu's instruction port (`imem_addr`/`imem_data`) and a slow, handshaked instruction memory. Hits return the instruction combinationally in the same cycle. A miss holds `imem_valid` low and presents a NOP, then refills the whole line byte-by-byte over a req/ack interface. The cpu, or the glue logic around it, stalls PC advance while `imem_valid` is low.

## Interface
- `LINES`, 8: number of cache lines (power of two).
- `LINE_BYTES`, 4: bytes per line (power of two).
- `ADDR_W`, 8: instruction address width. Tag width is `ADDR_W − log2(LINES) − log2(LINE_BYTES)`, 3 bits at defaults.
- `NOP_WORD`, 8'hC0: instruction driven when there is no hit (arith op 00, NOP).

Ports:
- `clk` input 1: single clock; all state is updated on the rising edge.
- `areset` input 1: asynchronous, active-low reset.
- `imem_addr` input ADDR_W: fetch address from the cpu PC.
- `imem_data` output 8: instruction on a hit, otherwise `NOP_WORD`.
- `imem_valid` output 1: high when `imem_data` is a real cached instruction.
- `flush` input 1: invalidates all lines, synchronous.
- `mem_req` output 1: refill request for one byte.
- `mem_addr` output ADDR_W: byte address being requested.
- `mem_ack` input 1: the byte on `mem_data` is valid this cycle.
- `mem_data` input 8: refill byte.
- `hit_count` output 16: present only with `ICACHE_STATS_EN`.
- `miss_count` output 16: present only with `ICACHE_STATS_EN`.

## Operation
- Address split: {tag, index, offset}.
- Storage:
  - per-line valid bit, tag register and `LINE_BYTES`-byte data array;
  - read path is asynchronous (combinational lookup).
- Hit condition: `state==IDLE && valid[index] && tag[index]==tag && !flush`.
  - On a hit: `imem_valid=1` and `imem_data=data[index][offset]`.
  - Otherwise: `imem_valid=0` and `imem_data=NOP_WORD`.
- State machine:
  - IDLE → REFILL on a miss with `flush` low.
    - Latch `{tag, index}`, clear byte counter `cnt`, set `mem_req=1`.
    - `mem_addr={tag, index, 0}`.
  - REFILL, on each cycle with `mem_ack=1`:
    - write `mem_data` to `data[index][cnt]`;
    - `cnt++`;
    - `mem_addr` advances to `{tag, index, cnt+1}` for the next cycle.
  - REFILL → IDLE on the ack with `cnt==LINE_BYTES−1`.
    - Set `valid[index]=1` and `tag[index]`=latched tag.
    - Drop `mem_req`.
- Handshake: `mem_req` and `mem_addr` are registered and stable until `mem_ack`. Back-to-back acks are allowed, one byte per cycle.
- Refill always fetches bytes in order from offset 0. There is no critical-word-first.
- `imem_addr` changing during REFILL has no effect on the refill in progress. The lookup is re-evaluated in IDLE.
- `flush`:
  - clears all valid bits at the edge;
  - in REFILL, aborts the refill: return to IDLE, `mem_req=0`, and any same-cycle ack byte is discarded;
  - flush coinciding with the final ack: flush wins and the line stays invalid.
- Reset (`areset` low):
  - all valid bits 0, state IDLE, `cnt=0`, `mem_req=0`, `mem_addr=0`;
  - hence `imem_valid=0` and `imem_data=NOP_WORD`;
  - counters 0;
  - reset asserted mid-refill abandons the refill immediately.

## Timing
- Hit latency: 0 cycles (combinational from `imem_addr`).
- Miss penalty with zero-wait memory (`mem_ack` high every REFILL cycle):
  - cycle 0: miss detected;
  - cycles 1–4: REFILL acks;
  - cycle 5: hit.
  - Total: `LINE_BYTES+1` cycles.
- With wait states, each byte costs one cycle plus the ack delay.
- At most one outstanding request. `mem_req` deasserts in the cycle after the final ack.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on each cycle with `imem_valid=1`;
  - `miss_count` increments on each IDLE→REFILL transition;
  - both are 16-bit, saturate at 16'hFFFF, are cleared only by reset and are unaffected by `flush`.
- `ICACHE_STATS_EN` undefined: the ports and counter logic are absent. All other behaviour is identical.

## Structure
- `icache_pkg`:
  - state enum {IDLE, REFILL};
  - `OFF_W`, `IDX_W` and `TAG_W` derived from the default parameters;
  - `NOP_WORD`.
- One sub-module, `icache_refill`:
  - holds the FSM, `cnt`, the latched tag/index and `mem_req`/`mem_addr`;
  - emits the write-enable, write-index and write-offset for the arrays.
- The top level holds the valid, tag and data arrays, the hit compare and the optional counters.

## Test plan
- Reset, then `imem_addr`=8'h00 → `imem_valid=0`, `imem_data`=8'hC0; `mem_req` rises next cycle with `mem_addr`=8'h00.
- Cold miss at 8'h05, zero-wait memory returning addr^8'hA5 → `mem_addr` 04,05,06,07 on consecutive cycles; hit at cycle 5 with `imem_data`=8'hA0; 8'h06 then hits with 8'hA3.
- Conflict: 8'h25 evicts the line holding 8'h05 → 8'h05 misses again.
- Wait states (ack every 3rd cycle) → `mem_addr` holds until ack; the line completes after 12 REFILL cycles.
- Flush on the final ack of a refill → line invalid; the next lookup misses and a new refill starts.
- With `ICACHE_STATS_EN`: 1 cold miss followed by 4 hit cycles → `miss_count=1`, `hit_count=4`; forcing the counter to 16'hFFFF keeps it at 16'hFFFF on further hits.
